reg_file_sb: RTL

//  8x8 register file with operand bypass and busy scoreboard; sits directly upstream of the ALU.
//  - OUT1 drives ALU DATA1; OUT2 drives the DATA2 operand mux.
//  - ALU RESULT returns on IN at writeback.
//  - The scoreboard tracks registers awaiting a result from multi-cycle ALU ops (mult) and raises STALL
//    so the control unit holds the PC until operands are valid.

---
 rtl/reg_file_sb_pkg.sv | 15 +
 rtl/reg_file_sb_scoreboard.sv | 28 ++
 rtl/reg_file_sb.sv | 43 ++++
 3 files changed

// File: rtl/reg_file_sb_pkg.sv
// reg_file_sb_pkg: shared widths, types and helpers for the register file and its scoreboard
package reg_file_sb_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 3;
  localparam int NUM_REGS   = 2 ** ADDR_WIDTH;
  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [NUM_REGS-1:0]   busy_t;
  function automatic logic bypass_hit(input logic we, input addr_t wa, input addr_t ra);
    return we && (wa == ra);
  endfunction
  function automatic busy_t onehot(input logic en, input addr_t a);
    return en ? busy_t'(1) << a : '0;
  endfunction
endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// reg_scoreboard: busy bit per register for in-flight multi-cycle results, plus operand stall
// ports: clk, rst_n (async active-low), issue/issue_address mark busy, write/in_address clear busy,
//        out1_address/out2_address source operands; busy vector and stall out
module reg_scoreboard
  import reg_file_sb_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  issue,
  input  addr_t issue_address,
  input  logic  write,
  input  addr_t in_address,
  input  addr_t out1_address,
  input  addr_t out2_address,
  output busy_t busy,
  output logic  stall
);
  logic byp1, byp2;
  // clear first, then set, so a same-address issue and write leaves the register busy
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) busy <= '0;
    else busy <= (busy & ~onehot(write, in_address)) | onehot(issue, issue_address);
  always_comb begin
    byp1  = bypass_hit(write, in_address, out1_address);
    byp2  = bypass_hit(write, in_address, out2_address);
    stall = rst_n && ((busy[out1_address] && !byp1) || (busy[out2_address] && !byp2));
  end
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: 8x8 register file with same-cycle write bypass and busy scoreboard stall
// ports: clk, rst_n (async active-low), in/in_address/write writeback, out1_address/out2_address
//        read addresses, issue/issue_address multi-cycle issue; out1/out2 bypassed operands,
//        stall, busy vector
module reg_file_sb
  import reg_file_sb_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  data_t in,
  input  addr_t in_address,
  input  logic  write,
  input  addr_t out1_address,
  input  addr_t out2_address,
  input  logic  issue,
  input  addr_t issue_address,
  output data_t out1,
  output data_t out2,
  output logic  stall,
  output busy_t busy
);
  data_t regs [NUM_REGS];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) regs <= '{default: '0};
    else if (write) regs[in_address] <= in;
  // outputs forced to zero while reset is held, even if a bypassing write is presented
  always_comb begin
    out1 = !rst_n ? '0 : bypass_hit(write, in_address, out1_address) ? in : regs[out1_address];
    out2 = !rst_n ? '0 : bypass_hit(write, in_address, out2_address) ? in : regs[out2_address];
  end
  reg_scoreboard u_sb (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue        (issue),
    .issue_address(issue_address),
    .write        (write),
    .in_address   (in_address),
    .out1_address (out1_address),
    .out2_address (out2_address),
    .busy         (busy),
    .stall        (stall)
  );
endmodule
